// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button/switch input conditioner.
// The counter width helper is evaluated at elaboration time only.
package btn_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } btn_state_e;

  localparam int DEFAULT_STABLE_CYCLES = 1_000_000;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >>> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One-bit synchronizer + debounce FSM producing level, press/release pulses and toggle.
// Latency: STABLE_CYCLES+2 edges from a raw change to outputs; no backpressure, free-running.
module debounce_channel
  import btn_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_toggle
);

  localparam int CW = (clog2(STABLE_CYCLES) > 0) ? clog2(STABLE_CYCLES) : 1;
  // The count reaching STABLE_CYCLES-1 is decided one step early, from the current sync2.
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 2);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          toggle_q, toggle_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOW;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      LOW: begin
        if (sync2_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sync2_q) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HIGH: begin
        if (!sync2_q) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (sync2_q) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    press_d   = (state_q == WAIT_HIGH) && sync2_q && (cnt_q == CNT_LAST);
    release_d = (state_q == WAIT_LOW) && !sync2_q && (cnt_q == CNT_LAST);
    level_d   = level_q;
    if (press_d) begin
      level_d = 1'b1;
    end
    if (release_d) begin
      level_d = 1'b0;
    end
    toggle_d  = toggle_q ^ press_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      toggle_q  <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      toggle_q  <= toggle_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_toggle  = toggle_q;

endmodule

// File: rtl/button_conditioner.sv
// N_BTN independent debounced button channels for the stopwatch control inputs.
// Latency: STABLE_CYCLES+2 edges per accepted change; no backpressure, free-running.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN         = 5,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_toggle
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_raw    (btn_raw[g]),
      .btn_level  (btn_level[g]),
      .btn_press  (btn_press[g]),
      .btn_release(btn_release[g]),
      .btn_toggle (btn_toggle[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: expected press/release events are queued when stimulus is driven.
module tb_button_conditioner;

  localparam int N = 5;
  localparam int S = 4;
  localparam int LAT = S + 2;

  typedef struct {
    int chan;
    bit rel;
    int cyc;
    bit tog;
  } ev_t;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic [N-1:0] btn_toggle;

  int     cyc;
  int     errors;
  int     checks;
  ev_t    evq[$];
  logic [N-1:0] exp_tog;

  button_conditioner #(
    .N_BTN(N),
    .STABLE_CYCLES(S)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_toggle (btn_toggle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    ev_t e;
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (btn_press[i] || btn_release[i]) begin
          checks++;
          if (evq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event chan=%0d press=%0b release=%0b cyc=%0d", i, btn_press[i], btn_release[i], cyc);
          end else begin
            e = evq.pop_front();
            if (e.chan != i || btn_release[i] !== e.rel || btn_press[i] === btn_release[i] ||
                e.cyc != cyc || btn_toggle[i] !== e.tog || btn_level[i] !== !e.rel) begin
              errors++;
              $display("FAIL event got chan=%0d press=%0b rel=%0b cyc=%0d tog=%0b lvl=%0b expected chan=%0d rel=%0b cyc=%0d tog=%0b",
                       i, btn_press[i], btn_release[i], cyc, btn_toggle[i], btn_level[i], e.chan, e.rel, e.cyc, e.tog);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  task automatic goto(input int t);
    if (t < cyc) begin
      checks++;
      errors++;
      $display("FAIL goto target=%0d now=%0d", t, cyc);
    end
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_ev(input int ch, input bit rel, input int at);
    ev_t e;
    if (!rel) exp_tog[ch] = ~exp_tog[ch];
    e.chan = ch;
    e.rel  = rel;
    e.cyc  = at;
    e.tog  = exp_tog[ch];
    evq.push_back(e);
  endtask

  task automatic check_vec(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b expected=%b cyc=%0d", name, got, exp, cyc);
    end
  endtask

  task automatic do_reset();
    checks++;
    if (evq.size() != 0) begin
      errors++;
      $display("FAIL missing_events pending=%0d expected=0", evq.size());
      evq.delete();
    end
    btn_raw = '0;
    rst_n = 1'b0;
    exp_tog = '0;
    goto(cyc + 2);
    rst_n = 1'b1;
    goto(cyc + 2);
  endtask

  task automatic test_reset();
    int c;
    btn_raw = 5'b11111;
    rst_n = 1'b0;
    exp_tog = '0;
    goto(3);
    check_vec("reset_level", btn_level, '0);
    check_vec("reset_press", btn_press, '0);
    check_vec("reset_release", btn_release, '0);
    check_vec("reset_toggle", btn_toggle, '0);
    goto(cyc + 1);
    rst_n = 1'b1;
    c = cyc;
    for (int i = 0; i < N; i++) expect_ev(i, 1'b0, c + LAT);
    goto(c + LAT - 1);
    check_vec("reset_level_early", btn_level, '0);
    goto(c + LAT);
    check_vec("reset_level_up", btn_level, 5'b11111);
    goto(c + LAT + 1);
    check_vec("reset_press_one_cycle", btn_press, '0);
    btn_raw = '0;
    c = cyc;
    for (int i = 0; i < N; i++) expect_ev(i, 1'b1, c + LAT);
    goto(c + LAT + 2);
    check_vec("reset_level_down", btn_level, '0);
  endtask

  task automatic test_clean_press();
    int c;
    do_reset();
    btn_raw[1] = 1'b1;
    c = cyc;
    expect_ev(1, 1'b0, c + LAT);
    goto(c + LAT - 1);
    check_vec("clean_level_early", btn_level, '0);
    goto(c + LAT);
    check_vec("clean_press", btn_press, 5'b00010);
    check_vec("clean_toggle", btn_toggle, 5'b00010);
    goto(c + LAT + 1);
    check_vec("clean_press_end", btn_press, '0);
    goto(c + 20);
    btn_raw[1] = 1'b0;
    expect_ev(1, 1'b1, c + 20 + LAT);
    goto(c + 20 + LAT);
    check_vec("clean_release", btn_release, 5'b00010);
    check_vec("clean_toggle_hold", btn_toggle, 5'b00010);
    goto(c + 20 + LAT + 2);
  endtask

  task automatic test_bounce();
    logic [6:0] pat;
    int c;
    do_reset();
    pat = 7'b0111011; // bit k is the value for cycle k: 1,1,0,1,1,1,0
    c = cyc;
    for (int k = 0; k < 7; k++) begin
      goto(c + k);
      btn_raw[2] = pat[k];
    end
    goto(c + 7);
    btn_raw[2] = 1'b1;
    expect_ev(2, 1'b0, c + 7 + LAT);
    goto(c + 7 + LAT - 1);
    check_vec("bounce_level_early", btn_level, '0);
    goto(c + 7 + LAT);
    check_vec("bounce_level", btn_level, 5'b00100);
    btn_raw[2] = 1'b0;
    expect_ev(2, 1'b1, c + 7 + 2 * LAT);
    goto(c + 7 + 2 * LAT + 2);
  endtask

  task automatic test_terminal_glitch();
    int c;
    do_reset();
    btn_raw[0] = 1'b1;
    c = cyc;
    goto(c + 3);
    btn_raw[0] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      goto(c + 3 + k);
      check_vec("glitch_level", btn_level, '0);
    end
  endtask

  task automatic test_toggle();
    logic [2:0] tog_seq;
    int c;
    do_reset();
    tog_seq = 3'b101;
    for (int p = 0; p < 3; p++) begin
      btn_raw[3] = 1'b1;
      c = cyc;
      expect_ev(3, 1'b0, c + LAT);
      goto(c + LAT + 1);
      checks++;
      if (btn_toggle[3] !== tog_seq[p]) begin
        errors++;
        $display("FAIL toggle_press%0d got=%b expected=%b", p, btn_toggle[3], tog_seq[p]);
      end
      goto(c + LAT + 2);
      btn_raw[3] = 1'b0;
      c = cyc;
      expect_ev(3, 1'b1, c + LAT);
      goto(c + LAT + 2);
      checks++;
      if (btn_toggle[3] !== tog_seq[p]) begin
        errors++;
        $display("FAIL toggle_release%0d got=%b expected=%b", p, btn_toggle[3], tog_seq[p]);
      end
    end
  endtask

  task automatic test_async_reset();
    int c;
    do_reset();
    btn_raw[1] = 1'b1;
    c = cyc;
    expect_ev(1, 1'b0, c + LAT);
    goto(c + LAT + 2);
    btn_raw[4] = 1'b1;
    c = cyc;
    goto(c + 4);
    #2;
    rst_n = 1'b0;
    #1;
    check_vec("async_level_cleared", btn_level, '0);
    check_vec("async_toggle_cleared", btn_toggle, '0);
    exp_tog = '0;
    goto(cyc + 2);
    rst_n = 1'b1;
    c = cyc;
    expect_ev(1, 1'b0, c + LAT);
    expect_ev(4, 1'b0, c + LAT);
    goto(c + LAT - 1);
    check_vec("async_level_early", btn_level, '0);
    goto(c + LAT);
    check_vec("async_level_up", btn_level, 5'b10010);
    btn_raw = '0;
    c = cyc;
    expect_ev(1, 1'b1, c + LAT);
    expect_ev(4, 1'b1, c + LAT);
    goto(c + LAT + 2);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    btn_raw = '0;
    exp_tog = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_terminal_glitch();
    test_toggle();
    test_async_reset();
    goto(cyc + 3);
    checks++;
    if (evq.size() != 0) begin
      errors++;
      $display("FAIL final_missing_events pending=%0d expected=0", evq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end input conditioner for the stopwatch's push-buttons and switches (reset, pause, adjust, select). It synchronizes each raw pin into the clock domain and debounces it with a per-channel stability counter. It then produces a clean level, a one-cycle press pulse, a one-cycle release pulse and a press-toggle per channel. Its outputs feed the stopwatch core's control inputs directly.

## Interface

- `N_BTN`, default 5: number of independent input channels.
- `STABLE_CYCLES`, default 1_000_000: number of consecutive synchronized samples (10 ms at 100 MHz) a new value must hold before it is accepted. Legal range is ≥2.
- `clk`  in  1  system clock; all state is on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `btn_raw`  in  N_BTN  raw asynchronous pins, active-high.
- `btn_level`  out  N_BTN  debounced level.
- `btn_press`  out  N_BTN  one-cycle pulse on each accepted 0→1 transition.
- `btn_release`  out  N_BTN  one-cycle pulse on each accepted 1→0 transition.
- `btn_toggle`  out  N_BTN  flips on every `btn_press`; used as the run/pause latch.

## Operation

- Each channel is independent and identical; there is no cross-channel interaction.
- **Synchronizer:** two flops per channel, `sync1 <= btn_raw`, `sync2 <= sync1`. Only `sync2` is used downstream.
- **Per-channel FSM**, 4 states:
  - **LOW:** level is 0. If `sync2 == 1`, clear the counter and go to WAIT_HIGH.
  - **WAIT_HIGH:** If `sync2 == 0`, return to LOW with the counter cleared; no outputs change. Otherwise increment the counter. When the counter reaches `STABLE_CYCLES-1`, go to HIGH and assert level=1, press=1, and toggle the toggle output.
  - **HIGH:** mirror of LOW. If `sync2 == 0`, go to WAIT_LOW.
  - **WAIT_LOW:** mirror of WAIT_HIGH. On terminal count go to LOW with level=0 and release=1.
- The counter width is ceil(log2(STABLE_CYCLES)). The counter saturates and never wraps, because it is always cleared on state exit.
- `btn_press` and `btn_release` are registered. They are high for exactly one cycle and never both high in the same cycle on one channel.
- `btn_toggle` changes only on press, never on release.

## Timing

- **Reset values:** all outputs are 0, both synchronizer stages are 0, every FSM is in LOW, and all counters are 0.
- **Acceptance latency:** suppose `btn_raw` rises and is stable before edge k. Then `sync2` is 1 after edge k+1. `btn_level` and `btn_press` go high after edge k+1+STABLE_CYCLES. Release timing is symmetric.
- **Glitch rejection:** a bounce whose `sync2` high run is shorter than STABLE_CYCLES produces no output change. The counter restarts from 0 on the next qualifying edge.
- **Glitch at the terminal cycle:** if `sync2` drops in the same cycle the counter would reach terminal count, the transition is rejected, because the decision uses the current `sync2`.
- **Reset mid-operation:** the reset is asynchronous and clears everything immediately, including a pending WAIT state and an active pulse. A button held through deassertion is re-accepted STABLE_CYCLES+2 edges after `rst_n` rises, giving level=1 and a fresh press pulse.
- **Simultaneous changes:** presses on several channels in the same cycle each produce their own pulse in the same output cycle.
- **Throughput:** the minimum spacing between two accepted presses on one channel is 2·STABLE_CYCLES cycles.

## Structure

- **Package `btn_pkg`:**
  - typedef for the state enum: LOW, WAIT_HIGH, HIGH, WAIT_LOW.
  - constant `DEFAULT_STABLE_CYCLES`.
  - function `clog2` for the counter width.
- **Sub-module `debounce_channel`:** one bit wide, containing the synchronizer, the FSM, the counter and the three pulse/toggle flops.
  - `button_conditioner` instantiates it N_BTN times in a generate loop.
  - No other logic lives in the top.

## Test plan

All scenarios run with STABLE_CYCLES=4 and N_BTN=5.

1. **Reset:** hold `rst_n`=0 with `btn_raw`=5'b11111, then release. All outputs are 0 during reset. All five `btn_level` bits rise together 6 edges after deassertion, each with a single press pulse.
2. **Clean press/release on bit 1:** raise bit 1 at edge 10 and hold it for 20 cycles, then drop it. Level and press appear at edge 15, with press lasting 1 cycle and toggle going 0→1. Release pulses at edge 35, and the toggle stays at 1.
3. **Bounce:** drive bit 2 with the pattern 1,1,0,1,1,1,0 and then a solid 1. No output occurs until 4 consecutive `sync2` ones; exactly one press pulse results.
4. **Terminal-cycle glitch:** drive bit 0 high for exactly 3 synced cycles, then low. There is no press and the level stays at 0.
5. **Toggle:** give bit 3 three clean presses. `btn_toggle` reads 1, 0, 1, with one press pulse per press and no pulse on release.
6. **Async reset inside WAIT_HIGH:** assert `rst_n` two cycles into the count. Outputs clear without waiting for a clock edge. After release with the button still held, the press occurs STABLE_CYCLES+2 edges later.
